// File: rtl/audio_mixer_n_pkg.sv
// Shared types and width helpers for the N-channel audio mixer.
// Pan encoding and accumulator width are used by the mixer and its bench.
package audio_mixer_n_pkg;

  typedef enum logic [1:0] {
    PAN_OFF   = 2'b00,
    PAN_LEFT  = 2'b01,
    PAN_RIGHT = 2'b10,
    PAN_BOTH  = 2'b11
  } mixer_pan_t;

  // Product width plus enough headroom for NCH products and the beeper/tape constants.
  function automatic int unsigned mixer_aw(int unsigned nch, int unsigned dw);
    return dw + 4 + $clog2(nch + 1);
  endfunction

endpackage

// File: rtl/sigma_delta_dac.sv
// First-order sigma-delta modulator: the registered carry of a W-bit phase
// accumulator gives a bitstream whose ones density is din / 2**W.
module sigma_delta_dac #(
  parameter int unsigned W = 8
) (
  input  logic         clk28,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic         dout
);

  logic [W:0] acc_q, acc_d;

  always_comb begin
    acc_d = {1'b0, acc_q[W-1:0]} + {1'b0, din};
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign dout = acc_q[W];

endmodule

// File: rtl/audio_mixer_n.sv
// Time-multiplexed N-channel mixer: one channel per clk28 cycle, then a latch slot
// that publishes the frame sums and feeds a sigma-delta DAC per side.
module audio_mixer_n
  import audio_mixer_n_pkg::*;
#(
  parameter int unsigned NCH        = 4,
  parameter int unsigned DW         = 8,
  parameter int unsigned BEEP_LEVEL = 2048,
  parameter int unsigned TAPE_LEVEL = 1024,
  localparam int unsigned AW        = mixer_aw(NCH, DW)
) (
  input  logic              clk28,
  input  logic              rst,
  input  logic [NCH*DW-1:0] ch_data,
  input  logic [NCH*4-1:0]  ch_vol,
  input  logic [NCH*2-1:0]  ch_pan,
  input  logic              beeper,
  input  logic              tape,
  input  logic              mute,
  output logic [AW-1:0]     sample_l,
  output logic [AW-1:0]     sample_r,
  output logic              sample_valid,
  output logic              dac_l,
  output logic              dac_r
);

  localparam int unsigned IW = $clog2(NCH + 1);
  localparam int unsigned PW = DW + 4;

  if (BEEP_LEVEL + TAPE_LEVEL >= (1 << PW)) begin : g_level_check
    $error("BEEP_LEVEL + TAPE_LEVEL must be below 2**(DW+4)");
  end

  logic [IW-1:0] idx_q, idx_d;
  logic [AW-1:0] acc_l_q, acc_l_d;
  logic [AW-1:0] acc_r_q, acc_r_d;
  logic [AW-1:0] sample_l_q, sample_l_d;
  logic [AW-1:0] sample_r_q, sample_r_d;
  logic          valid_q;

  logic          last_slot;
  logic [DW-1:0] cur_data;
  logic [3:0]    cur_vol;
  mixer_pan_t    cur_pan;
  logic [PW-1:0] prod;
  logic          add_l, add_r;
  logic [AW-1:0] beep_add, tape_add;

  assign last_slot = (idx_q == IW'(NCH));
  assign beep_add  = beeper ? AW'(BEEP_LEVEL) : '0;
  assign tape_add  = tape ? AW'(TAPE_LEVEL) : '0;

  // Select the channel owning the current slot; the latch slot selects nothing.
  always_comb begin
    cur_data = '0;
    cur_vol  = '0;
    cur_pan  = PAN_OFF;
    for (int k = 0; k < NCH; k++) begin
      if (idx_q == IW'(k)) begin
        cur_data = ch_data[k*DW +: DW];
        cur_vol  = ch_vol[k*4 +: 4];
        cur_pan  = mixer_pan_t'(ch_pan[k*2 +: 2]);
      end
    end
  end

  assign prod = PW'(cur_data) * PW'(cur_vol);

  always_comb begin
    add_l = 1'b0;
    add_r = 1'b0;
    unique case (cur_pan)
      PAN_LEFT:  add_l = 1'b1;
      PAN_RIGHT: add_r = 1'b1;
      PAN_BOTH: begin
        add_l = 1'b1;
        add_r = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    idx_d      = last_slot ? '0 : idx_q + IW'(1);
    acc_l_d    = acc_l_q;
    acc_r_d    = acc_r_q;
    sample_l_d = sample_l_q;
    sample_r_d = sample_r_q;
    if (last_slot) begin
      // The latch slot carries no channel, so clearing here drops nothing.
      acc_l_d    = '0;
      acc_r_d    = '0;
      sample_l_d = mute ? '0 : acc_l_q + beep_add + tape_add;
      sample_r_d = mute ? '0 : acc_r_q + beep_add + tape_add;
    end else begin
      if (add_l) acc_l_d = acc_l_q + AW'(prod);
      if (add_r) acc_r_d = acc_r_q + AW'(prod);
    end
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      idx_q      <= '0;
      acc_l_q    <= '0;
      acc_r_q    <= '0;
      sample_l_q <= '0;
      sample_r_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      acc_l_q    <= acc_l_d;
      acc_r_q    <= acc_r_d;
      sample_l_q <= sample_l_d;
      sample_r_q <= sample_r_d;
      valid_q    <= last_slot;
    end
  end

  assign sample_l     = sample_l_q;
  assign sample_r     = sample_r_q;
  assign sample_valid = valid_q;

  sigma_delta_dac #(
    .W (AW)
  ) u_dac_l (
    .clk28 (clk28),
    .rst   (rst),
    .din   (sample_l_q),
    .dout  (dac_l)
  );

  sigma_delta_dac #(
    .W (AW)
  ) u_dac_r (
    .clk28 (clk28),
    .rst   (rst),
    .din   (sample_r_q),
    .dout  (dac_r)
  );

endmodule

// File: tb/tb_audio_mixer_n.sv
// Scoreboard bench for audio_mixer_n: a 4-channel/8-bit instance and a 1-channel/4-bit
// instance; stimulus pushes expected frame sums, monitors pop them on sample_valid.
module tb_audio_mixer_n;

  logic clk28 = 1'b0;
  logic rst   = 1'b1;
  always #5 clk28 = ~clk28;

  // 4-channel instance (AW = 15)
  logic [31:0] ch_data = '0;
  logic [15:0] ch_vol  = '0;
  logic [7:0]  ch_pan  = '0;
  logic        beeper  = 1'b0;
  logic        tape    = 1'b0;
  logic        mute    = 1'b0;
  logic [14:0] sample_l, sample_r;
  logic        sample_valid, dac_l, dac_r;

  audio_mixer_n #(
    .NCH        (4),
    .DW         (8),
    .BEEP_LEVEL (2048),
    .TAPE_LEVEL (1024)
  ) dut (
    .clk28        (clk28),
    .rst          (rst),
    .ch_data      (ch_data),
    .ch_vol       (ch_vol),
    .ch_pan       (ch_pan),
    .beeper       (beeper),
    .tape         (tape),
    .mute         (mute),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .dac_l        (dac_l),
    .dac_r        (dac_r)
  );

  // 1-channel instance (AW = 9): ch0 = 15, vol 15, LEFT
  logic [3:0] ch_data1 = 4'd15;
  logic [3:0] ch_vol1  = 4'd15;
  logic [1:0] ch_pan1  = 2'b01;
  logic       zero1    = 1'b0;
  logic [8:0] sample_l1, sample_r1;
  logic       sample_valid1, dac_l1, dac_r1;

  audio_mixer_n #(
    .NCH        (1),
    .DW         (4),
    .BEEP_LEVEL (64),
    .TAPE_LEVEL (32)
  ) dut1 (
    .clk28        (clk28),
    .rst          (rst),
    .ch_data      (ch_data1),
    .ch_vol       (ch_vol1),
    .ch_pan       (ch_pan1),
    .beeper       (zero1),
    .tape         (zero1),
    .mute         (zero1),
    .sample_l     (sample_l1),
    .sample_r     (sample_r1),
    .sample_valid (sample_valid1),
    .dac_l        (dac_l1),
    .dac_r        (dac_r1)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int exp_l[$], exp_r[$];
  int exp_l1[$], exp_r1[$];
  int last_v   = -1;
  int last_v1  = -1;

  always @(posedge clk28) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int l, input int r);
    exp_l.push_back(l);
    exp_r.push_back(r);
  endtask

  // Monitor for the 4-channel instance
  always @(posedge clk28) begin
    int el, er;
    #1;
    if (rst) begin
      last_v = -1;
    end else if (sample_valid) begin
      if (last_v >= 0) chk("valid_spacing", cyc - last_v, 5);
      last_v = cyc;
      if (exp_l.size() > 0) begin
        el = exp_l.pop_front();
        er = exp_r.pop_front();
        chk("sample_l", int'(sample_l), el);
        chk("sample_r", int'(sample_r), er);
      end
    end
  end

  // Monitor for the 1-channel instance
  always @(posedge clk28) begin
    int el, er;
    #1;
    if (rst) begin
      last_v1 = -1;
    end else if (sample_valid1) begin
      if (last_v1 >= 0) chk("n1_valid_spacing", cyc - last_v1, 2);
      last_v1 = cyc;
      if (exp_l1.size() > 0) begin
        el = exp_l1.pop_front();
        er = exp_r1.pop_front();
        chk("n1_sample_l", int'(sample_l1), el);
        chk("n1_sample_r", int'(sample_r1), er);
      end
    end
  end

  task automatic set_ch(input int k, input int data, input int vol, input int pan);
    ch_data[k*8 +: 8] = 8'(data);
    ch_vol[k*4 +: 4]  = 4'(vol);
    ch_pan[k*2 +: 2]  = 2'(pan);
  endtask

  // Returns at the negedge where sample_valid is high.
  task automatic wait_valid(input string name);
    int t;
    t = 0;
    do begin
      @(negedge clk28);
      t++;
    end while (!sample_valid && t < 50);
    if (!sample_valid) chk({name, "_valid_timeout"}, 0, 1);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_l.size() > 0 && t < 100) begin
      @(negedge clk28);
      t++;
    end
    chk({name, "_drain_left"}, exp_l.size(), 0);
  endtask

  task automatic count_ones(input int n, output int ol, output int orr);
    ol  = 0;
    orr = 0;
    repeat (n) begin
      @(negedge clk28);
      ol  += int'(dac_l);
      orr += int'(dac_r);
    end
  endtask

  // 1-channel instance: values, spacing and DAC densities
  initial begin
    int ol, orr, t;
    wait (rst == 1'b0);
    repeat (10) @(negedge clk28);
    repeat (3) begin
      exp_l1.push_back(225);
      exp_r1.push_back(0);
    end
    t = 0;
    while (exp_l1.size() > 0 && t < 50) begin
      @(negedge clk28);
      t++;
    end
    chk("n1_drain_left", exp_l1.size(), 0);
    ol  = 0;
    orr = 0;
    repeat (512) begin
      @(negedge clk28);
      ol  += int'(dac_l1);
      orr += int'(dac_r1);
    end
    chk("n1_dac_l_ones_512", ol, 225);
    chk("n1_dac_r_ones_512", orr, 0);
  end

  initial begin
    int ol, orr, n;

    // Reset state
    set_ch(0, 255, 15, 3);
    repeat (3) @(posedge clk28);
    #1;
    chk("reset_sample_l", int'(sample_l), 0);
    chk("reset_sample_r", int'(sample_r), 0);
    chk("reset_valid", int'(sample_valid), 0);
    chk("reset_dac_l", int'(dac_l), 0);
    @(negedge clk28);
    rst = 1'b0;

    // ch0 only, BOTH
    repeat (3) push(3825, 3825);
    drain("t1");
    count_ones(32768, ol, orr);
    chk("t1_dac_l_ones", ol, 3825);
    chk("t1_dac_r_ones", orr, 3825);

    // ch1 LEFT, ch2 RIGHT, beeper
    @(negedge clk28);
    set_ch(0, 255, 15, 0);
    set_ch(1, 16, 1, 1);
    set_ch(2, 32, 2, 2);
    beeper = 1'b1;
    repeat (3) wait_valid("t2_settle");
    repeat (3) push(2064, 2112);
    drain("t2");

    // All channels full scale, BOTH, beeper + tape
    @(negedge clk28);
    for (int k = 0; k < 4; k++) set_ch(k, 255, 15, 3);
    tape = 1'b1;
    repeat (3) wait_valid("t3_settle");
    repeat (3) push(18372, 18372);
    drain("t3");
    count_ones(32768, ol, orr);
    chk("t3_dac_l_ones", ol, 18372);
    chk("t3_dac_r_ones", orr, 18372);

    // One-cycle reset at slot 2
    wait_valid("t4_align");
    repeat (2) @(negedge clk28);
    rst = 1'b1;
    @(posedge clk28);
    #1;
    chk("t4_rst_sample_l", int'(sample_l), 0);
    chk("t4_rst_sample_r", int'(sample_r), 0);
    chk("t4_rst_dac_l", int'(dac_l), 0);
    chk("t4_rst_dac_r", int'(dac_r), 0);
    n = 1;
    @(negedge clk28);
    rst = 1'b0;
    repeat (2) push(18372, 18372);
    while (n < 20) begin
      @(posedge clk28);
      #1;
      n++;
      if (sample_valid) break;
    end
    chk("t4_first_valid_latency", n, 6);
    drain("t4");

    // Mute across one frame end, then restore
    wait_valid("t5_align");
    push(0, 0);
    mute = 1'b1;
    wait_valid("t5_muted");
    mute = 1'b0;
    push(18372, 18372);
    wait_valid("t5_restored");
    drain("t5");

    repeat (5) @(negedge clk28);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
